// File: rtl/debug_ocimem_ctrl.sv
// Debug-monitor RAM controller: runs decoded JTAG ocimem commands and
// shares the RAM with the CPU-side Avalon debug slave port.
module debug_ocimem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_JRD1,
        S_JRD2,
        S_JWR,
        S_ARD1,
        S_ARD2
    } state_t;

    typedef enum logic [1:0] {
        C_NONE,
        C_A,
        C_NA,
        C_B
    } cmd_t;

    state_t            r_state;
    state_t            w_state_nxt;
    cmd_t              w_pulse_cmd;
    cmd_t              w_exec_cmd;
    cmd_t              r_pend_cmd;
    logic              r_pend_vld;
    logic [37:0]       r_pend_jdo;
    logic [37:0]       w_exec_jdo;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_aaddr;
    logic [31:0]       r_mondreg;
    logic [31:0]       r_readdata;
    logic              r_ready;
    logic              r_error;
    logic [31:0]       r_mem [DEPTH];

    logic              w_pulse;
    logic              w_idle;
    logic              w_go;
    logic              w_store;
    logic              w_drop;
    logic              w_avs_free;
    logic              w_avs_rd_acc;
    logic              w_jaddr_ok;
    logic              w_aaddr_ok;
    logic              w_avs_ok;
    logic              w_jwr_en;
    logic              w_awr_en;
    logic [IDX_W-1:0]  w_jidx;
    logic [IDX_W-1:0]  w_aidx;
    logic [IDX_W-1:0]  w_avidx;
    logic              w_unused_jdo;

    always_comb begin
        w_pulse_cmd = C_NONE;
        unique case (1'b1)
            take_action_ocimem_a:    w_pulse_cmd = C_A;
            take_no_action_ocimem_a: w_pulse_cmd = C_NA;
            take_action_ocimem_b:    w_pulse_cmd = C_B;
            default:                 w_pulse_cmd = C_NONE;
        endcase
    end

    assign w_pulse    = (w_pulse_cmd != C_NONE);
    assign w_idle     = (r_state == S_IDLE);
    assign w_exec_cmd = r_pend_vld ? r_pend_cmd : w_pulse_cmd;
    assign w_exec_jdo = r_pend_vld ? r_pend_jdo : jdo;
    assign w_go       = w_idle && (w_exec_cmd != C_NONE);

    // In IDLE the pending command runs and a new pulse refills the slot.
    assign w_store = w_pulse && (w_idle ? r_pend_vld : !r_pend_vld);
    assign w_drop  = w_pulse && !w_idle && r_pend_vld;

    assign w_avs_free   = w_idle && !w_pulse && !r_pend_vld && !reset;
    assign w_avs_rd_acc = w_avs_free && avs_read && !avs_write;

    assign w_jaddr_ok = (32'(r_addr) < DEPTH_U);
    assign w_aaddr_ok = (32'(r_aaddr) < DEPTH_U);
    assign w_avs_ok   = (32'(avs_address) < DEPTH_U);
    assign w_jidx     = r_addr[IDX_W-1:0];
    assign w_aidx     = r_aaddr[IDX_W-1:0];
    assign w_avidx    = avs_address[IDX_W-1:0];

    assign w_jwr_en = w_go && (w_exec_cmd == C_B) && w_jaddr_ok && !reset;
    assign w_awr_en = w_avs_free && avs_write && w_avs_ok;

    assign avs_waitrequest = !((w_avs_free && avs_write) ||
                               ((r_state == S_ARD2) && !reset));

    assign avs_readdata  = r_readdata;
    assign MonDReg       = r_mondreg;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
    assign w_unused_jdo  = ^{w_exec_jdo[37], w_exec_jdo[2:0]};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    case (w_exec_cmd)
                        C_A:     w_state_nxt = w_exec_jdo[35] ? S_JRD1 : S_IDLE;
                        C_NA:    w_state_nxt = S_JRD1;
                        C_B:     w_state_nxt = S_JWR;
                        default: w_state_nxt = S_IDLE;
                    endcase
                end else if (w_avs_rd_acc) begin
                    w_state_nxt = S_ARD1;
                end
            end
            S_JRD1:  w_state_nxt = S_JRD2;
            S_JRD2:  w_state_nxt = S_IDLE;
            S_JWR:   w_state_nxt = S_IDLE;
            S_ARD1:  w_state_nxt = S_ARD2;
            S_ARD2:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_vld <= 1'b0;
            r_pend_cmd <= C_NONE;
            r_pend_jdo <= '0;
            r_addr     <= '0;
            r_aaddr    <= '0;
            r_mondreg  <= '0;
            r_readdata <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_store) begin
                r_pend_vld <= 1'b1;
                r_pend_cmd <= w_pulse_cmd;
                r_pend_jdo <= jdo;
            end else if (w_go && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            if (w_go) begin
                case (w_exec_cmd)
                    C_A: begin
                        r_addr  <= w_exec_jdo[ADDR_W+16:17];
                        r_ready <= !w_exec_jdo[35];
                        if (w_exec_jdo[36]) begin
                            r_error <= 1'b0;
                        end
                    end
                    C_NA: begin
                        r_ready <= 1'b0;
                    end
                    C_B: begin
                        r_ready <= 1'b1;
                        r_addr  <= r_addr + 1'b1;
                        if (!w_jaddr_ok) begin
                            r_error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (r_state == S_JRD1) begin
                r_mondreg <= w_jaddr_ok ? r_mem[w_jidx] : '0;
                r_ready   <= 1'b1;
                r_addr    <= r_addr + 1'b1;
                if (!w_jaddr_ok) begin
                    r_error <= 1'b1;
                end
            end

            if (w_avs_rd_acc) begin
                r_aaddr <= avs_address;
            end
            if (r_state == S_ARD1) begin
                r_readdata <= w_aaddr_ok ? r_mem[w_aidx] : '0;
            end

            // Queued work means the host must not see the earlier completion.
            if (w_store) begin
                r_ready <= 1'b0;
            end
            if (w_drop) begin
                r_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_jwr_en) begin
            r_mem[w_jidx] <= w_exec_jdo[34:3];
        end else if (w_awr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    r_mem[w_avidx][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Directed/random bench for debug_ocimem_ctrl against a word-array
// model of the monitor RAM, host address pointer and error flag.
module tb_debug_ocimem_ctrl;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_a;
    logic              take_na;
    logic              take_b;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    always #5 clk = ~clk;

    debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [31:0]       ref_mem [2**ADDR_W];
    logic [ADDR_W-1:0] ref_addr;
    logic              ref_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_rd();
        logic [31:0] v;
        if (32'(ref_addr) < DEPTH) begin
            v = ref_mem[ref_addr];
        end else begin
            v = '0;
            ref_err = 1'b1;
        end
        ref_addr = ref_addr + 1'b1;
        return v;
    endfunction

    task automatic ref_wr(input logic [31:0] d);
        if (32'(ref_addr) < DEPTH) ref_mem[ref_addr] = d;
        else ref_err = 1'b1;
        ref_addr = ref_addr + 1'b1;
    endtask

    task automatic rd_tail(input string tag);
        logic [31:0] exp;
        #2;
        chk({tag, "_rdy_t1"}, 32'(monitor_ready), 32'd0);
        step();
        #2;
        exp = ref_rd();
        chk({tag, "_data"}, MonDReg, exp);
        chk({tag, "_rdy_t2"}, 32'(monitor_ready), 32'd1);
        chk({tag, "_err"}, 32'(monitor_error), 32'(ref_err));
        step();
    endtask

    task automatic jt_a(input logic [ADDR_W-1:0] a, input bit rd,
                        input bit clr);
        jdo = '0;
        jdo[ADDR_W+16:17] = a;
        jdo[35] = rd;
        jdo[36] = clr;
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        ref_addr = a;
        if (clr) ref_err = 1'b0;
        if (rd) begin
            rd_tail("a_rd");
        end else begin
            #2;
            chk("a_set_rdy", 32'(monitor_ready), 32'd1);
            chk("a_set_err", 32'(monitor_error), 32'(ref_err));
        end
    endtask

    task automatic jt_na();
        take_na = 1'b1;
        step();
        take_na = 1'b0;
        rd_tail("na_rd");
    endtask

    task automatic jt_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_b = 1'b1;
        step();
        take_b = 1'b0;
        ref_wr(d);
        #2;
        chk("b_rdy", 32'(monitor_ready), 32'd1);
        chk("b_err", 32'(monitor_error), 32'(ref_err));
        step();
    endtask

    task automatic av_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        #2;
        chk("av_wr_wait", 32'(avs_waitrequest), 32'd0);
        step();
        avs_write = 1'b0;
        if (32'(a) < DEPTH) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic av_rd(input logic [ADDR_W-1:0] a);
        int          lat;
        logic [31:0] got;
        logic [31:0] exp;
        exp = (32'(a) < DEPTH) ? ref_mem[a] : '0;
        avs_address = a;
        avs_read    = 1'b1;
        lat = -1;
        got = '0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (!avs_waitrequest) begin
                lat = i;
                got = avs_readdata;
                break;
            end
            step();
        end
        avs_read = 1'b0;
        step();
        chk("av_rd_lat", 32'(lat), 32'd2);
        chk("av_rd_data", got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]       d;
        logic [31:0]       e1;
        logic [31:0]       e2;
        logic [ADDR_W-1:0] a;
        int                lat;
        logic [31:0]       got;

        reset = 1'b1;
        jdo = '0;
        take_a = 1'b0;
        take_na = 1'b0;
        take_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        ref_addr = '0;
        ref_err = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        #2;
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_ready", 32'(monitor_ready), 32'd0);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_wait", 32'(avs_waitrequest), 32'd1);
        chk("rst_rdata", avs_readdata, 32'd0);

        jt_a(9'h010, 1'b0, 1'b0);
        jt_b(32'hCAFEF00D);
        jt_b($urandom);
        jt_a(9'h010, 1'b1, 1'b0);
        chk("plan_cafe", MonDReg, 32'hCAFEF00D);
        jt_na();

        for (int i = 0; i < 6; i++) begin
            a = ADDR_W'($urandom_range(DEPTH - 1, 0));
            jt_a(a, 1'b0, 1'b0);
            jt_b($urandom);
            jt_b($urandom);
            jt_a(a, 1'b1, 1'b0);
            jt_na();
        end

        jt_a(9'h000, 1'b0, 1'b1);
        d = $urandom;
        jt_b(d);
        jt_a(9'h1FF, 1'b0, 1'b0);
        jt_b($urandom);
        chk("wrap_err", 32'(monitor_error), 32'd1);
        jt_na();
        chk("wrap_rd0", MonDReg, d);
        jt_a(9'h000, 1'b0, 1'b1);
        chk("err_clr", 32'(monitor_error), 32'd0);
        jt_a(9'h100, 1'b1, 1'b0);
        chk("oor_rd", MonDReg, 32'd0);
        jt_a(9'h000, 1'b0, 1'b1);

        av_wr(9'd5, 32'hFFFFFFFF, 4'hF);
        av_wr(9'd5, 32'h12345678, 4'b0011);
        av_rd(9'd5);
        chk("plan_av5", avs_readdata, 32'hFFFF5678);
        jt_a(9'd5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = ADDR_W'($urandom_range(DEPTH - 1, 0));
            av_wr(a, $urandom, 4'hF);
            av_wr(a, $urandom, 4'($urandom_range(15, 0)));
            av_rd(a);
        end
        av_wr(9'h0A0, $urandom, 4'hF);
        av_wr(9'h1A0, $urandom, 4'hF);
        av_rd(9'h0A0);
        av_rd(9'h1A0);
        chk("av_oor_noerr", 32'(monitor_error), 32'd0);

        jt_a(9'h020, 1'b0, 1'b0);
        repeat (3) jt_b($urandom);
        jdo = '0;
        jdo[ADDR_W+16:17] = 9'h020;
        jdo[35] = 1'b1;
        take_a = 1'b1;
        avs_address = 9'd5;
        avs_read = 1'b1;
        #2;
        chk("arb_wait_t0", 32'(avs_waitrequest), 32'd1);
        step();
        take_a = 1'b0;
        ref_addr = 9'h020;
        e1 = ref_rd();
        e2 = ref_rd();
        take_na = 1'b1;
        #2;
        chk("arb_wait_t1", 32'(avs_waitrequest), 32'd1);
        step();
        take_na = 1'b0;
        jdo = '0;
        jdo[34:3] = $urandom;
        take_b = 1'b1;
        #2;
        chk("arb_rd1", MonDReg, e1);
        chk("arb_rdy_pend", 32'(monitor_ready), 32'd0);
        step();
        take_b = 1'b0;
        ref_err = 1'b1;
        #2;
        chk("arb_drop_err", 32'(monitor_error), 32'd1);
        lat = -1;
        got = '0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                chk("arb_rd2", MonDReg, e2);
                chk("arb_rd2_rdy", 32'(monitor_ready), 32'd1);
            end
            if (!avs_waitrequest) begin
                lat = i;
                got = avs_readdata;
                break;
            end
            step();
            #2;
        end
        avs_read = 1'b0;
        step();
        chk("arb_av_lat", 32'(lat), 32'd5);
        chk("arb_av_data", got, ref_mem[5]);
        jt_na();
        jt_a(9'h000, 1'b0, 1'b1);

        jt_a(9'h180, 1'b1, 1'b0);
        jt_a(9'h010, 1'b1, 1'b0);
        jdo = '0;
        jdo[ADDR_W+16:17] = 9'h011;
        jdo[35] = 1'b1;
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ref_addr = '0;
        ref_err = 1'b0;
        #2;
        chk("rstmid_mondreg", MonDReg, 32'd0);
        chk("rstmid_ready", 32'(monitor_ready), 32'd0);
        chk("rstmid_error", 32'(monitor_error), 32'd0);
        chk("rstmid_wait", 32'(avs_waitrequest), 32'd1);
        jt_a(9'h011, 1'b1, 1'b0);

        jt_a(9'h030, 1'b0, 1'b0);
        jt_b($urandom);
        jt_a(9'h030, 1'b0, 1'b0);
        jdo = '0;
        jdo[34:3] = $urandom;
        take_b = 1'b1;
        reset = 1'b1;
        step();
        take_b = 1'b0;
        reset = 1'b0;
        ref_addr = '0;
        ref_err = 1'b0;
        #2;
        chk("rstwr_ready", 32'(monitor_ready), 32'd0);
        jt_a(9'h030, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
